// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: canonical NOP,
// default reset PC and the queue entry layout used by fetch_fifo.
package fetch_pkg;

    // Width of the default entry type below.
    localparam int FETCH_XLEN = 32;

    // addi x0,x0,0 -- what decode sees whenever no instruction is queued.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // First fetch address after reset unless the top overrides it.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    // One queue slot: the PC an instruction was fetched from and the word itself.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with a single-cycle flush.
// DEPTH must be a power of two (>= 2) so the read/write pointers wrap
// naturally; count is one bit wider than the pointers so "full" and
// "empty" are distinguishable. The head is read straight from storage,
// so nothing on push_data reaches head in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    // Qualify push/pop against the occupancy so the FIFO never over/underflows.
    always_comb begin
        push_ok_s = push && (count_r != CW'(DEPTH));
        pop_ok_s  = pop  && (count_r != {CW{1'b0}});
    end

    // Pointer and occupancy tracking; reset and flush both return to empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; a push that coincides with reset or flush is dropped.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a decoupling prefetch queue.
// Generates sequential fetch addresses, buffers {pc, insn} pairs in a
// DEPTH-entry fetch_fifo and hands them to decode over valid/ready.
// Decode sees the canonical NOP (and PC 0) whenever the queue is empty.
// A redirect flushes the queue and restarts fetch at the new word-aligned PC.
// Optional feature macro: FETCH_STATS_EN adds stat_fetched/stat_flushed.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int              DEPTH    = 4
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            stop,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] command,
    output logic [XLEN-1:0] now_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_flushed
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Queue slot sized to this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } entry_t;

    logic [XLEN-1:0] pc_r;
    logic            fetch_s;
    logic            deq_s;
    entry_t          push_s;
    entry_t          head_s;
    logic [CW-1:0]   count_s;
    logic            full_s;
    logic            empty_s;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (fetch_s),
        .push_data (push_s),
        .pop       (deq_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Request and handshake qualification; out_ready never feeds mem_req.
    always_comb begin
        mem_req     = !rst && !redirect && !stop && !full_s;
        fetch_s     = mem_req && mem_valid;
        deq_s       = !rst && !redirect && !stop && !empty_s && out_ready;
        push_s.pc   = pc_r;
        push_s.insn = mem_data;
    end

    // Decode-facing view of the queue head, forced to NOP/0 when empty.
    always_comb begin
        out_valid = !empty_s;
        if (empty_s) begin
            command = XLEN'(NOP_INSN);
            now_pc  = {XLEN{1'b0}};
        end else begin
            command = head_s.insn;
            now_pc  = head_s.pc;
        end
    end

    // Fetch PC: reset > redirect (word-aligned) > advance on accepted fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (redirect) begin
            pc_r <= redirect_pc & ~XLEN'(32'd3);
        end else if (fetch_s) begin
            pc_r <= pc_r + XLEN'(32'd4);
        end else begin
            pc_r <= pc_r;
        end
    end

    assign mem_addr = pc_r;

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_r;
    logic [31:0] stat_flushed_r;

    // Event counters: accepted fetches, and entries discarded by redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched_r <= 32'd0;
            stat_flushed_r <= 32'd0;
        end else begin
            if (fetch_s) begin
                stat_fetched_r <= stat_fetched_r + 32'd1;
            end
            if (redirect) begin
                stat_flushed_r <= stat_flushed_r + 32'(count_s);
            end
        end
    end

    assign stat_fetched = stat_fetched_r;
    assign stat_flushed = stat_flushed_r;
`else
    // Occupancy is only needed by the statistics counters.
    logic unused_count_s;
    assign unused_count_s = ^count_s;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (XLEN=32, DEPTH=4).
// A tiny memory model answers every request with a word derived from
// the requested address, so expected command values follow from the PC.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        stop;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] command;
    logic [31:0] now_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_queue #(
        .XLEN     (32),
        .RESET_PC (32'h8000_0000),
        .DEPTH    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stop         (stop),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_valid    (mem_valid),
        .mem_data     (mem_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .command      (command),
        .now_pc       (now_pc)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched (stat_fetched),
        .stat_flushed (stat_flushed)
`endif
    );

    always #5 clk = ~clk;

    // Instruction word the memory model returns for an address.
    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then answer the new request address.
    task automatic cyc();
        #1;
        @(posedge clk);
        #1;
        mem_data = insn_of(mem_addr);
        #1;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stop = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        mem_valid = 1'b0; out_ready = 1'b0; mem_data = 32'h0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        // Reset state
        chk("rst_mem_req",   {31'd0, mem_req},   32'd1);
        chk("rst_mem_addr",  mem_addr,           32'h8000_0000);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_command",   command,            NOP);
        chk("rst_now_pc",    now_pc,             32'h0);
`ifdef FETCH_STATS_EN
        chk("rst_stat_fetched", stat_fetched, 32'd0);
        chk("rst_stat_flushed", stat_flushed, 32'd0);
`endif

        // Fill the queue with decode stalled
        mem_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("full_mem_req",   {31'd0, mem_req},   32'd0);
        chk("full_mem_addr",  mem_addr,           32'h8000_0010);
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        chk("full_now_pc",    now_pc,             32'h8000_0000);
        chk("full_command",   command,            insn_of(32'h8000_0000));
        cyc();
        chk("full_hold_addr", mem_addr,           32'h8000_0010);
        out_ready = 1'b1;
        #1;
        chk("full_no_bypass", {31'd0, mem_req},   32'd0);

        // Drain one entry; fetch resumes next cycle
        cyc();
        chk("drain_now_pc",  now_pc,            32'h8000_0004);
        chk("drain_mem_req", {31'd0, mem_req},  32'd1);
        chk("drain_addr",    mem_addr,          32'h8000_0010);

        // Sustained one-per-cycle flow with three entries in flight
        for (int j = 1; j <= 4; j++) begin
            cyc();
            chk("stream_now_pc",  now_pc,   32'h8000_0004 + 32'(4 * j));
            chk("stream_command", command,  insn_of(32'h8000_0004 + 32'(4 * j)));
            chk("stream_addr",    mem_addr, 32'h8000_0010 + 32'(4 * j));
        end

        // Redirect with three entries queued
        redirect = 1'b1; redirect_pc = 32'h8000_0103;
        #1;
        chk("redir_mem_req_low", {31'd0, mem_req}, 32'd0);
        cyc();
        redirect = 1'b0;
        #1;
        chk("redir_out_valid", {31'd0, out_valid}, 32'd0);
        chk("redir_command",   command,            NOP);
        chk("redir_now_pc",    now_pc,             32'h0);
        chk("redir_addr",      mem_addr,           32'h8000_0100);
        chk("redir_mem_req",   {31'd0, mem_req},   32'd1);
`ifdef FETCH_STATS_EN
        chk("redir_stat_flushed", stat_flushed, 32'd3);
        chk("redir_stat_fetched", stat_fetched, 32'd8);
`endif

        // Stop freezes everything for five cycles
        cyc();
        chk("pre_stop_now_pc", now_pc, 32'h8000_0100);
        stop = 1'b1;
        #1;
        chk("stop_mem_req", {31'd0, mem_req}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("stop_addr",    mem_addr, 32'h8000_0104);
            chk("stop_now_pc",  now_pc,   32'h8000_0100);
            chk("stop_command", command,  insn_of(32'h8000_0100));
        end
        stop = 1'b0;
        cyc();
        chk("resume_now_pc", now_pc,   32'h8000_0104);
        chk("resume_addr",   mem_addr, 32'h8000_0108);

        // Redirect wins over stop
        stop = 1'b1; redirect = 1'b1; redirect_pc = 32'h8000_2000;
        cyc();
        stop = 1'b0; redirect = 1'b0;
        #1;
        chk("redir_stop_addr",      mem_addr,           32'h8000_2000);
        chk("redir_stop_out_valid", {31'd0, out_valid}, 32'd0);
        chk("redir_stop_mem_req",   {31'd0, mem_req},   32'd1);
`ifdef FETCH_STATS_EN
        chk("redir_stop_flushed", stat_flushed, 32'd4);
        chk("redir_stop_fetched", stat_fetched, 32'd10);
`endif

        // Reset wins over redirect
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h1234_5678;
        cyc();
        rst = 1'b0; redirect = 1'b0;
        #1;
        chk("rst_redir_addr",      mem_addr,           32'h8000_0000);
        chk("rst_redir_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef FETCH_STATS_EN
        chk("rst_redir_fetched", stat_fetched, 32'd0);
        chk("rst_redir_flushed", stat_flushed, 32'd0);
`endif

        // Address wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        cyc();
        redirect = 1'b0;
        #1;
        chk("wrap_start_addr", mem_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_addr0",    mem_addr, 32'h0000_0000);
        chk("wrap_now_pc0",  now_pc,   32'hFFFF_FFFC);
        chk("wrap_command0", command,  insn_of(32'hFFFF_FFFC));
        cyc();
        chk("wrap_addr1",     mem_addr,           32'h0000_0004);
        chk("wrap_now_pc1",   now_pc,             32'h0000_0000);
        chk("wrap_out_valid", {31'd0, out_valid}, 32'd1);

        // Memory not answering: queue drains, PC holds
        mem_valid = 1'b0;
        cyc();
        chk("nomem_out_valid", {31'd0, out_valid}, 32'd0);
        chk("nomem_command",   command,            NOP);
        chk("nomem_addr",      mem_addr,           32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a decoupling prefetch queue between instruction memory and decode. It generates sequential fetch addresses and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It presents them to decode over a valid/ready handshake and supplies the canonical NOP (addi x0,x0,0) whenever no instruction is available. A redirect from writeback flushes the queue and restarts fetch at the new PC. It replaces the single-register fetch stage at the front of the core pipeline.

## Interface
- XLEN, 32: address/instruction width.
- RESET_PC, 32'h8000_0000: first fetch address after reset.
- DEPTH, 4: queue entries; power of two, ≥2.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- stop  in  1  pause: freezes PC, queue and outputs.
- redirect  in  1  load redirect_pc and flush queue (was wb_pc).
- redirect_pc  in  XLEN  new fetch address; bits [1:0] are forced to 0.
- mem_req  out  1  fetch request this cycle.
- mem_addr  out  XLEN  fetch address (= pc).
- mem_valid  in  1  memory accepts the request and returns mem_data this cycle.
- mem_data  in  XLEN  instruction word for mem_addr.
- out_valid  out  1  command/now_pc hold a real instruction.
- out_ready  in  1  decode consumes the head entry.
- command  out  XLEN  head instruction; NOP 32'h0000_0013 when out_valid=0.
- now_pc  out  XLEN  PC of head entry; 0 when out_valid=0.

## Operation
- Priority: rst > redirect > stop > normal.
- rst: pc←RESET_PC, queue emptied, count←0; stats cleared.
- mem_req = !rst && !redirect && !stop && (count < DEPTH). There is no full-and-dequeue bypass; mem_req has no combinational dependence on out_ready.
- Fetch handshake: mem_req && mem_valid → enqueue {mem_addr, mem_data}, pc←pc+4 (modulo 2^XLEN, wraps silently).
- Dequeue: out_valid && out_ready && !stop && !redirect → head removed.
- Enqueue and dequeue in the same cycle: count unchanged, both take effect.
- redirect: queue flushed (count←0, pointers reset), pc←{redirect_pc[XLEN-1:2],2'b00}. A concurrent dequeue is discarded, as is any memory response. Applies even when stop=1.
- stop without redirect: no enqueue, no dequeue, pc held, outputs stable.
- out_valid = (count != 0). The head is read from queue storage, so the output does not pass through combinationally from mem_data.
- Full (count==DEPTH): mem_req=0; pc holds until decode drains one entry.
- Empty: command=NOP, now_pc=0, out_valid=0.

## Timing
- Reset outputs (cycle after rst sampled): mem_req=1 (if stop=0), mem_addr=RESET_PC, out_valid=0, command=NOP, now_pc=0.
- Fetch-to-decode latency: 1 cycle. An instruction accepted at edge N is visible on command/now_pc after edge N.
- Redirect at edge N: mem_addr=redirect_pc and out_valid=0 after edge N. mem_req reasserts in the cycle after N if redirect is deasserted.
- Throughput: 1 instruction/cycle sustained when mem_valid=1 and out_ready=1.
- Counter width: $clog2(DEPTH)+1; pointers $clog2(DEPTH), wrapping naturally.

## Configuration
- FETCH_STATS_EN defined: adds outputs stat_fetched (32) and stat_flushed (32).
  - stat_fetched increments per enqueue.
  - stat_flushed adds count at each redirect.
  - Both wrap and reset to 0.
- FETCH_STATS_EN undefined: ports and counters are absent; functional behaviour is identical.

## Structure
- Shared package fetch_pkg: NOP_INSN constant 32'h0000_0013, default RESET_PC, typedef fetch_entry_t {pc, insn}.
- One sub-module, fetch_fifo: generic synchronous FIFO with flush, parametrised DEPTH and entry type, exposing count/full/empty.
- PC register, request logic and stats live in fetch_queue.

## Test plan
- Reset, then mem_valid=1 and out_ready=1 constantly → after reset, mem_addr steps 8000_0000, 8000_0004, …; now_pc trails by one cycle; command equals mem_data.
- out_ready=0 with mem_valid=1, DEPTH=4 → after 4 accepts mem_req=0 and mem_addr=8000_0010. Raising out_ready drains 8000_0000 first and resumes fetch.
- Redirect to 8000_0103 with 3 entries queued → next cycle out_valid=0, command=0000_0013, mem_addr=8000_0100. With stats enabled, stat_flushed=3.
- stop=1 for 5 cycles with mem_valid and out_ready high → mem_req=0; command, now_pc and mem_addr unchanged. Resuming continues from the same address.
- Redirect and stop asserted together → redirect is honoured (pc loaded, queue flushed). rst and redirect together → pc=RESET_PC.
- Redirect to FFFF_FFFC, then fetch twice → mem_addr sequence FFFF_FFFC, 0000_0000.
